// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants and types for the RV32I multi-cycle sequencer:
// operand-type, writeback/PC select and trap-cause encodings, opcodes, FSM states.
package multicycle_ctrl_pkg;

  localparam logic [1:0] OP_TYPE_NONE = 2'd0;
  localparam logic [1:0] OP_TYPE_REG  = 2'd1;
  localparam logic [1:0] OP_TYPE_IMM  = 2'd2;
  localparam logic [1:0] OP_TYPE_PC   = 2'd3;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  localparam logic [1:0] PC_SEL_PC4 = 2'd0;
  localparam logic [1:0] PC_SEL_ALU = 2'd1;
  localparam logic [1:0] PC_SEL_BR  = 2'd2;

  localparam logic [1:0] TRAP_CAUSE_NONE    = 2'd0;
  localparam logic [1:0] TRAP_CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] TRAP_CAUSE_DMEM    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  typedef struct packed {
    logic       legal;
    logic [1:0] op1_type;
    logic [1:0] op2_type;
    logic [1:0] wb_sel;
    logic       is_mem;
    logic       is_store;
    logic       is_jump;
    logic       is_branch;
  } dec_t;

endpackage

// File: rtl/multicycle_ctrl_opdecode.sv
// Combinational opcode classifier: legality, ALU operand types and
// instruction-class flags for the sequencer.
module ctrl_opdecode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    case (opcode_i)
      OPC_OP: begin
        dec_o.legal    = 1'b1;
        dec_o.op1_type = OP_TYPE_REG;
        dec_o.op2_type = OP_TYPE_REG;
      end
      OPC_OP_IMM: begin
        dec_o.legal    = 1'b1;
        dec_o.op1_type = OP_TYPE_REG;
        dec_o.op2_type = OP_TYPE_IMM;
      end
      OPC_LOAD: begin
        dec_o.legal    = 1'b1;
        dec_o.op1_type = OP_TYPE_REG;
        dec_o.op2_type = OP_TYPE_IMM;
        dec_o.wb_sel   = WB_SEL_MEM;
        dec_o.is_mem   = 1'b1;
      end
      OPC_STORE: begin
        dec_o.legal    = 1'b1;
        dec_o.op1_type = OP_TYPE_REG;
        dec_o.op2_type = OP_TYPE_IMM;
        dec_o.is_mem   = 1'b1;
        dec_o.is_store = 1'b1;
      end
      OPC_LUI: begin
        dec_o.legal    = 1'b1;
        dec_o.op1_type = OP_TYPE_NONE;
        dec_o.op2_type = OP_TYPE_IMM;
      end
      OPC_AUIPC: begin
        dec_o.legal    = 1'b1;
        dec_o.op1_type = OP_TYPE_PC;
        dec_o.op2_type = OP_TYPE_IMM;
      end
      OPC_JAL: begin
        dec_o.legal    = 1'b1;
        dec_o.op1_type = OP_TYPE_PC;
        dec_o.op2_type = OP_TYPE_IMM;
        dec_o.wb_sel   = WB_SEL_PC4;
        dec_o.is_jump  = 1'b1;
      end
      OPC_JALR: begin
        dec_o.legal    = 1'b1;
        dec_o.op1_type = OP_TYPE_REG;
        dec_o.op2_type = OP_TYPE_IMM;
        dec_o.wb_sel   = WB_SEL_PC4;
        dec_o.is_jump  = 1'b1;
      end
      OPC_BRANCH: begin
        dec_o.legal     = 1'b1;
        dec_o.op1_type  = OP_TYPE_REG;
        dec_o.op2_type  = OP_TYPE_REG;
        dec_o.is_branch = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I execute datapath,
// with illegal-opcode and memory-timeout traps.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_we,
  output logic [1:0] aluop1_type,
  output logic [1:0] aluop2_type,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [6:0] opc_q, opc_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] cause_q, cause_d;
  dec_t       dec;

  logic       imem_req_q, dmem_req_q, dmem_we_q, reg_we_q, trap_q;
  logic       jump_wb_q, branch_ex_q;
  logic [1:0] op1_q, op2_q, wb_sel_q;

  // Decode the opcode the next state will see, so EXEC outputs can be registered.
  assign opc_d = (state_q == S_DECODE) ? opcode : opc_q;

  ctrl_opdecode u_opdecode (
    .opcode_i (opc_d),
    .dec_o    (dec)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          cnt_d   = '0;
          state_d = S_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_TRAP;
          cause_d = TRAP_CAUSE_IMEM;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (dec.legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = TRAP_CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (dec.is_mem)         state_d = S_MEM;
        else if (dec.is_branch) state_d = S_FETCH;
        else                    state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ready) begin
          cnt_d   = '0;
          state_d = dec.is_store ? S_FETCH : S_WB;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_TRAP;
          cause_d = TRAP_CAUSE_DMEM;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      opc_q       <= '0;
      cnt_q       <= '0;
      cause_q     <= TRAP_CAUSE_NONE;
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      trap_q      <= 1'b0;
      jump_wb_q   <= 1'b0;
      branch_ex_q <= 1'b0;
      op1_q       <= OP_TYPE_NONE;
      op2_q       <= OP_TYPE_NONE;
      wb_sel_q    <= WB_SEL_ALU;
    end else begin
      state_q     <= state_d;
      opc_q       <= opc_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      imem_req_q  <= (state_d == S_FETCH);
      dmem_req_q  <= (state_d == S_MEM);
      dmem_we_q   <= (state_d == S_MEM) && dec.is_store;
      reg_we_q    <= (state_d == S_WB);
      trap_q      <= (state_d == S_TRAP);
      jump_wb_q   <= (state_d == S_WB) && dec.is_jump;
      branch_ex_q <= (state_d == S_EXEC) && dec.is_branch;
      op1_q       <= (state_d == S_EXEC || state_d == S_MEM) ? dec.op1_type : OP_TYPE_NONE;
      op2_q       <= (state_d == S_EXEC || state_d == S_MEM) ? dec.op2_type : OP_TYPE_NONE;
      wb_sel_q    <= (state_d == S_WB) ? dec.wb_sel : WB_SEL_ALU;
    end
  end

  // Retirement of branches and stores depends on same-cycle inputs, so it is not registered.
  assign ir_we       = imem_req_q & imem_ready;
  assign pc_we       = reg_we_q | branch_ex_q | (dmem_we_q & dmem_ready);
  assign retire      = pc_we;
  assign pc_sel      = jump_wb_q                    ? PC_SEL_ALU :
                       (branch_ex_q & branch_taken) ? PC_SEL_BR  : PC_SEL_PC4;
  assign imem_req    = imem_req_q;
  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign reg_we      = reg_we_q;
  assign aluop1_type = op1_q;
  assign aluop2_type = op2_q;
  assign wb_sel      = wb_sel_q;
  assign trap        = trap_q;
  assign trap_cause  = cause_q;

endmodule
